spram_init_loader: RTL
======================

Name: spram_init_loader

Overview:
- Write-side front end placed directly upstream of the generic single-port RAM. It drives that RAM's address, data and write-enable inputs.
- Arbitrates three sources onto the single port: a hardware clear engine, a handshaked download stream (ROM/asset load), and normal core (CPU/video) accesses.
- All RAM-side outputs are registered, so the RAM sees clean, glitch-free, single-source control.

Parameters:
- address_width, 8: RAM address width; the RAM depth is 2**address_width words.
- data_width, 8: RAM word width.
- clear_value, 0: word written to every location during a clear (data_width bits).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clear_start  in  1  one-cycle request to fill the whole RAM with clear_value.
- dl_valid  in  1  download word present.
- dl_ready  out  1  loader accepts a download word this cycle.
- dl_addr  in  address_width  download target address.
- dl_data  in  data_width  download word.
- core_address  in  address_width  core access address.
- core_data  in  data_width  core write data.
- core_wren  in  1  core write strobe.
- ram_address  out  address_width  to RAM address (registered).
- ram_data  out  data_width  to RAM data (registered).
- ram_wren  out  1  to RAM wren (registered).
- busy  out  1  clear in progress (registered).
- clear_done  out  1  one-cycle pulse when the final clear write is issued (registered).

Behaviour:
- Reset (synchronous, sampled on a clk edge):
  - state=IDLE, counter=0.
  - ram_address=0, ram_data=0, ram_wren=0, busy=0, clear_done=0.
  - dl_ready=0 while reset is high.
- States: IDLE, CLEAR.
- dl_ready is combinational: (state==IDLE) && !clear_start && !reset.
- Transfer rule: a download word transfers on an edge where dl_valid && dl_ready.
- IDLE, source priority evaluated each edge:
  1. clear_start: state<=CLEAR, counter<=0, busy<=1, ram_wren<=0. The download is not accepted on this edge.
  2. dl_valid (with dl_ready): ram_address<=dl_addr, ram_data<=dl_data, ram_wren<=1. The core is ignored on this edge, including core_wren.
  3. Otherwise: ram_address<=core_address, ram_data<=core_data, ram_wren<=core_wren.
- CLEAR, one write per edge:
  - ram_address<=counter, ram_data<=clear_value, ram_wren<=1.
  - If counter == 2**address_width-1: state<=IDLE, busy<=0, clear_done<=1, counter<=0. Otherwise counter<=counter+1.
- CLEAR, ignored inputs: clear_start, dl_valid and all core inputs are ignored (core writes are dropped, not queued); dl_ready=0.
- clear_done is high for exactly one cycle and is 0 at all other times.
- Latency:
  - A source sampled at edge N appears on ram_* after edge N; the RAM commits it at edge N+1.
  - Core reads therefore see RAM q two edges after core_address is presented.
- Clear duration: exactly 2**address_width write cycles. busy is high from the edge after clear_start through the edge that issues the last write.
- Counter width: address_width bits, no overflow beyond the terminal compare.
- Reset during CLEAR: the clear aborts immediately and partially cleared contents are left as-is. ram_wren=0 on the next cycle; no clear_done pulse.
- clear_start and reset in the same cycle: reset wins.
- clear_start and dl_valid in the same cycle: clear wins; the download word stays pending (dl_ready=0) and is accepted after the clear completes.

Test Plan (address_width=4, data_width=8, clear_value=8'hA5 unless stated):
1. Assert reset for 2 cycles, then release -> all outputs 0, and dl_ready=1 on the first cycle after release with clear_start=0.
2. Pulse clear_start -> busy=1 for 16 cycles; ram_address steps 0..15 with ram_data=A5 and ram_wren=1; clear_done pulses once, coincident with address 15. An attached RAM then reads A5 at every address.
3. Download stream of 4 words to addresses 3,4,5,6 with data 11,22,33,44, dl_valid held high -> one write per cycle, ram_* follow with 1-cycle latency. Core reads return 11/22/33/44 with 2-cycle latency.
4. core_wren=1 to address 7 with data 5A in the same cycle as dl_valid to address 2 with data 77 -> only the address-2 write is issued; address 7 is unchanged.
5. clear_start together with dl_valid (address 9, data 99) -> dl_ready=0 for the whole clear. The word is written after clear_done, so address 9 reads 99 and all other addresses read A5.
6. Assert reset 5 cycles into a clear -> ram_wren=0 and busy=0 on the next cycle, no clear_done; addresses 0..3 read A5 and the rest hold their prior contents.

Source files
------------

// File: rtl/spram_init_loader.sv
// Write-side front end for a single-port RAM. It arbitrates a hardware clear
// engine, a handshaked download stream and normal core accesses onto the RAM
// port. The RAM-facing outputs are all registered, so the RAM only ever sees
// one clean source per cycle.
//
// Download handshake: a word transfers on a rising edge where dl_valid and
// dl_ready are both high. dl_ready is combinational and depends only on state,
// clear_start and reset, never on dl_valid. The source must hold dl_addr and
// dl_data stable while dl_valid is high and no transfer has happened yet.
module spram_init_loader #(
  parameter int                      address_width = 8,
  parameter int                      data_width    = 8,
  parameter logic [data_width-1:0]   clear_value   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_start,
  input  logic                       dl_valid,
  output logic                       dl_ready,
  input  logic [address_width-1:0]   dl_addr,
  input  logic [data_width-1:0]      dl_data,
  input  logic [address_width-1:0]   core_address,
  input  logic [data_width-1:0]      core_data,
  input  logic                       core_wren,
  output logic [address_width-1:0]   ram_address,
  output logic [data_width-1:0]      ram_data,
  output logic                       ram_wren,
  output logic                       busy,
  output logic                       clear_done,
  output logic                       state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                     state;
  logic [address_width-1:0]   counter;

  // The terminal address of the clear sweep; reaching it ends the clear.
  localparam logic [address_width-1:0] last_addr = '1;

  // Downloads are accepted only when idle and no clear is being requested.
  assign dl_ready = (state == IDLE) && !clear_start && !reset;

  // Exposes the current FSM state for observation (1 = clear in progress).
  assign state_dbg = (state == CLEAR);

  // Source arbitration and clear sweep; every RAM-facing output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      busy        <= 1'b0;
      clear_done  <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            // Address and data are left as they were; only the strobe drops.
            state    <= CLEAR;
            counter  <= '0;
            busy     <= 1'b1;
            ram_wren <= 1'b0;
          end else if (dl_valid) begin
            // Download has priority over the core; the core write is lost.
            ram_address <= dl_addr;
            ram_data    <= dl_data;
            ram_wren    <= 1'b1;
          end else begin
            ram_address <= core_address;
            ram_data    <= core_data;
            ram_wren    <= core_wren;
          end
        end
        CLEAR: begin
          // One clear write per cycle; all other inputs are ignored.
          ram_address <= counter;
          ram_data    <= clear_value;
          ram_wren    <= 1'b1;
          if (counter == last_addr) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
            counter    <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
